// File: rtl/lpddr3_lane_dly_stepper.sv
// Per-byte-lane driver for the LPDDR3 dynamic delay-line interface: paced LOAD/MOVE pulses inside a clock-pause window.
// Optional statistics counters are built when LANE_DLY_STEP_STATS_EN is defined.
module lpddr3_lane_dly_stepper #(
    parameter int TAP_W         = 8,
    parameter int INIT_TAP      = 1,
    parameter int PAUSE_LEAD    = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int PAUSE_LAG     = 2
) (
    input  logic             FAB_CLK,
    input  logic             RESET,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic             CMD_SEL,
    input  logic             CMD_DIR,
    input  logic             CMD_LOAD,
    input  logic [TAP_W-1:0] CMD_STEPS,
    output logic             DONE,
    output logic             ERR,
    output logic [TAP_W-1:0] RX_TAP,
    output logic [TAP_W-1:0] TX_TAP,
    output logic             DELAY_LINE_SEL,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_MOVE,
    output logic             HS_IO_CLK_PAUSE,
    input  logic             RX_DELAY_LINE_OUT_OF_RANGE,
    input  logic             TX_DELAY_LINE_OUT_OF_RANGE,
    output logic [15:0]      MOVE_CNT,
    output logic [7:0]       ABORT_CNT
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_LOAD, S_MOVE, S_GAP, S_POST, S_FIN
    } state_t;

    localparam logic [TAP_W-1:0] INIT_TAP_V = TAP_W'(INIT_TAP);
    localparam logic [TAP_W-1:0] TAP_MAX    = {TAP_W{1'b1}};
    localparam logic [3:0]       LEAD_M1    = 4'(PAUSE_LEAD - 1);
    localparam logic [3:0]       SETTLE_M1  = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       LAG_M1     = 4'(PAUSE_LAG - 1);

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [TAP_W-1:0] steps_q;
    logic             load_cmd_q;
    logic             ready_q, done_q, err_q, pause_q, load_q, move_q, sel_q, dir_q;
    logic [TAP_W-1:0] rx_tap_q, tx_tap_q, rx_tap_d, tx_tap_d, cur_tap_s, new_tap_s;
    logic             oor_s, abort_s;

    assign oor_s   = sel_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;
    assign abort_s = (state_q == S_GAP) && (cnt_q == 4'd0) && oor_s;

    // Tap tracker next state: follows the pulse that was just presented to the lane.
    always_comb begin
        rx_tap_d  = rx_tap_q;
        tx_tap_d  = tx_tap_q;
        cur_tap_s = sel_q ? tx_tap_q : rx_tap_q;
        new_tap_s = cur_tap_s;
        if (load_q) begin
            new_tap_s = INIT_TAP_V;
        end else if (move_q) begin
            if (dir_q) begin
                new_tap_s = (cur_tap_s == TAP_MAX) ? TAP_MAX : cur_tap_s + {{(TAP_W-1){1'b0}}, 1'b1};
            end else begin
                new_tap_s = (cur_tap_s == {TAP_W{1'b0}}) ? {TAP_W{1'b0}} : cur_tap_s - {{(TAP_W-1){1'b0}}, 1'b1};
            end
        end else begin
            new_tap_s = cur_tap_s;
        end
        if (sel_q) begin
            tx_tap_d = new_tap_s;
        end else begin
            rx_tap_d = new_tap_s;
        end
    end

    // Sequencer FSM; lane-facing strobes are registered from the current state, one cycle behind it.
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            steps_q    <= {TAP_W{1'b0}};
            load_cmd_q <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            pause_q    <= 1'b0;
            load_q     <= 1'b0;
            move_q     <= 1'b0;
            sel_q      <= 1'b0;
            dir_q      <= 1'b0;
            rx_tap_q   <= INIT_TAP_V;
            tx_tap_q   <= INIT_TAP_V;
        end else begin
            rx_tap_q <= rx_tap_d;
            tx_tap_q <= tx_tap_d;
            load_q   <= (state_q == S_LOAD);
            move_q   <= (state_q == S_MOVE);
            done_q   <= (state_q == S_FIN);
            pause_q  <= (state_q == S_PRE) || (state_q == S_LOAD) || (state_q == S_MOVE)
                        || (state_q == S_GAP) || (state_q == S_POST);
            case (state_q)
                S_IDLE: begin
                    if (CMD_VALID) begin
                        sel_q      <= CMD_SEL;
                        dir_q      <= CMD_DIR;
                        load_cmd_q <= CMD_LOAD;
                        steps_q    <= CMD_STEPS;
                        err_q      <= 1'b0;
                        ready_q    <= 1'b0;
                        cnt_q      <= LEAD_M1;
                        if ((CMD_STEPS == {TAP_W{1'b0}}) && !CMD_LOAD) begin
                            state_q <= S_FIN;
                        end else begin
                            state_q <= S_PRE;
                        end
                    end
                end
                S_PRE: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= load_cmd_q ? S_LOAD : S_MOVE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_LOAD: begin
                    state_q <= S_GAP;
                    cnt_q   <= SETTLE_M1;
                end
                S_MOVE: begin
                    steps_q <= steps_q - {{(TAP_W-1){1'b0}}, 1'b1};
                    state_q <= S_GAP;
                    cnt_q   <= SETTLE_M1;
                end
                S_GAP: begin
                    if (cnt_q == 4'd0) begin
                        if (oor_s) begin
                            err_q   <= 1'b1;
                            state_q <= S_POST;
                            cnt_q   <= LAG_M1;
                        end else if (steps_q != {TAP_W{1'b0}}) begin
                            state_q <= S_MOVE;
                        end else begin
                            state_q <= S_POST;
                            cnt_q   <= LAG_M1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_POST: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= S_FIN;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef LANE_DLY_STEP_STATS_EN
    logic [15:0] move_cnt_q;
    logic [7:0]  abort_cnt_q;

    // Saturating statistics; only RESET clears them.
    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            move_cnt_q  <= 16'd0;
            abort_cnt_q <= 8'd0;
        end else begin
            if ((state_q == S_MOVE) && (move_cnt_q != 16'hFFFF)) begin
                move_cnt_q <= move_cnt_q + 16'd1;
            end
            if (abort_s && (abort_cnt_q != 8'hFF)) begin
                abort_cnt_q <= abort_cnt_q + 8'd1;
            end
        end
    end

    assign MOVE_CNT  = move_cnt_q;
    assign ABORT_CNT = abort_cnt_q;
`else
    assign MOVE_CNT  = 16'd0;
    assign ABORT_CNT = 8'd0;
`endif

    assign CMD_READY            = ready_q;
    assign DONE                 = done_q;
    assign ERR                  = err_q;
    assign RX_TAP               = rx_tap_q;
    assign TX_TAP               = tx_tap_q;
    assign DELAY_LINE_SEL       = sel_q;
    assign DELAY_LINE_LOAD      = load_q;
    assign DELAY_LINE_DIRECTION = dir_q;
    assign DELAY_LINE_MOVE      = move_q;
    assign HS_IO_CLK_PAUSE      = pause_q;

endmodule
